// File: rtl/clause_len8.sv
// Clause literal counter: per-clause positive/negative/length counts, empty/unit/invalid flags and first literal index.
// Define CLAUSE_LEN8_REG_OUT_EN to register all outputs (1-cycle latency); otherwise outputs are combinational.
module clause_len8 #(
    parameter int NUM_VARS  = 8,
    parameter int WIDTH     = 4,
    parameter int WIDTH_IDX = 3
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    valid_i,
    input  logic [2*NUM_VARS-1:0]   clause_i,
    output logic                    valid_o,
    output logic [WIDTH-1:0]        len_o,
    output logic [WIDTH-1:0]        pos_cnt_o,
    output logic [WIDTH-1:0]        neg_cnt_o,
    output logic                    empty_o,
    output logic                    unit_o,
    output logic                    invalid_o,
    output logic [WIDTH_IDX-1:0]    first_idx_o
);

    localparam int unsigned MAX_CNT = (1 << WIDTH) - 1;

    function automatic logic [WIDTH-1:0] sat(input int unsigned c);
        if (c > MAX_CNT) return WIDTH'(MAX_CNT);
        return WIDTH'(c);
    endfunction

    logic [WIDTH-1:0]     len_d, pos_d, neg_d;
    logic                 empty_d, unit_d, invalid_d;
    logic [WIDTH_IDX-1:0] idx_d;

    always_comb begin
        int unsigned pos_n;
        int unsigned neg_n;
        logic [1:0]  lit;
        pos_n     = 0;
        neg_n     = 0;
        invalid_d = 1'b0;
        idx_d     = '0;
        lit       = 2'b00;
        // Walk downward so the lowest valid slot is the last one written.
        for (int k = NUM_VARS - 1; k >= 0; k--) begin
            lit = clause_i[2*k +: 2];
            if (lit == 2'b01) pos_n = pos_n + 1;
            if (lit == 2'b10) neg_n = neg_n + 1;
            if (lit == 2'b11) invalid_d = 1'b1;
            if (lit == 2'b01 || lit == 2'b10) idx_d = WIDTH_IDX'(k);
        end
        pos_d   = sat(pos_n);
        neg_d   = sat(neg_n);
        len_d   = sat(pos_n + neg_n);
        // Flags come from the true length, not the saturated one.
        empty_d = (pos_n + neg_n) == 0;
        unit_d  = (pos_n + neg_n) == 1;
    end

`ifdef CLAUSE_LEN8_REG_OUT_EN
    logic                 valid_q;
    logic [WIDTH-1:0]     len_q, pos_q, neg_q;
    logic                 empty_q, unit_q, invalid_q;
    logic [WIDTH_IDX-1:0] idx_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            valid_q   <= 1'b0;
            len_q     <= '0;
            pos_q     <= '0;
            neg_q     <= '0;
            empty_q   <= 1'b0;
            unit_q    <= 1'b0;
            invalid_q <= 1'b0;
            idx_q     <= '0;
        end else begin
            valid_q <= valid_i;
            if (valid_i) begin
                len_q     <= len_d;
                pos_q     <= pos_d;
                neg_q     <= neg_d;
                empty_q   <= empty_d;
                unit_q    <= unit_d;
                invalid_q <= invalid_d;
                idx_q     <= idx_d;
            end
        end
    end

    assign valid_o     = valid_q;
    assign len_o       = len_q;
    assign pos_cnt_o   = pos_q;
    assign neg_cnt_o   = neg_q;
    assign empty_o     = empty_q;
    assign unit_o      = unit_q;
    assign invalid_o   = invalid_q;
    assign first_idx_o = idx_q;
`else
    logic unused_clk_rst;
    assign unused_clk_rst = clk ^ rst;

    assign valid_o     = valid_i;
    assign len_o       = len_d;
    assign pos_cnt_o   = pos_d;
    assign neg_cnt_o   = neg_d;
    assign empty_o     = empty_d;
    assign unit_o      = unit_d;
    assign invalid_o   = invalid_d;
    assign first_idx_o = idx_d;
`endif

endmodule

// File: tb/tb_clause_len8.sv
// Directed bench for clause_len8: default 4-bit counts plus a 3-bit instance for saturation.
// Follows the build's CLAUSE_LEN8_REG_OUT_EN setting for latency and reset expectations.
module tb_clause_len8;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        valid_i = 1'b0;
    logic [15:0] clause_i = 16'h0000;

    logic       valid_o, empty_o, unit_o, invalid_o;
    logic [3:0] len_o, pos_o, neg_o;
    logic [2:0] idx_o;

    logic       valid3, empty3, unit3, invalid3;
    logic [2:0] len3, pos3, neg3;
    logic [2:0] idx3;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    clause_len8 dut (
        .clk(clk), .rst(rst), .valid_i(valid_i), .clause_i(clause_i),
        .valid_o(valid_o), .len_o(len_o), .pos_cnt_o(pos_o), .neg_cnt_o(neg_o),
        .empty_o(empty_o), .unit_o(unit_o), .invalid_o(invalid_o), .first_idx_o(idx_o)
    );

    clause_len8 #(.WIDTH(3)) dut_w3 (
        .clk(clk), .rst(rst), .valid_i(valid_i), .clause_i(clause_i),
        .valid_o(valid3), .len_o(len3), .pos_cnt_o(pos3), .neg_cnt_o(neg3),
        .empty_o(empty3), .unit_o(unit3), .invalid_o(invalid3), .first_idx_o(idx3)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Drive on the falling edge, then sample where the result is expected.
    task automatic drive(input logic v, input logic [15:0] c);
        @(negedge clk);
        valid_i  = v;
        clause_i = c;
`ifdef CLAUSE_LEN8_REG_OUT_EN
        @(posedge clk);
`endif
        #1;
    endtask

    task automatic run_vec(input string name, input logic [15:0] c,
                           input int len, input int pos, input int neg,
                           input bit emp, input bit uni, input bit inv, input int idx,
                           input int len_w3, input int pos_w3, input int neg_w3);
        drive(1'b1, c);
        check({name, ".valid"}, valid_o, 1);
        check({name, ".len"}, len_o, len);
        check({name, ".pos"}, pos_o, pos);
        check({name, ".neg"}, neg_o, neg);
        check({name, ".empty"}, empty_o, emp);
        check({name, ".unit"}, unit_o, uni);
        check({name, ".invalid"}, invalid_o, inv);
        check({name, ".idx"}, idx_o, idx);
        check({name, ".w3_len"}, len3, len_w3);
        check({name, ".w3_pos"}, pos3, pos_w3);
        check({name, ".w3_neg"}, neg3, neg_w3);
        check({name, ".w3_empty"}, empty3, emp);
        check({name, ".w3_unit"}, unit3, uni);
    endtask

    initial begin
        #12;
`ifdef CLAUSE_LEN8_REG_OUT_EN
        check("rst.valid", valid_o, 0);
        check("rst.empty", empty_o, 0);
        check("rst.len", len_o, 0);
        check("rst.invalid", invalid_o, 0);
`else
        check("rst.valid", valid_o, 0);
        check("rst.empty", empty_o, 1);
        check("rst.len", len_o, 0);
`endif
        @(negedge clk);
        rst = 1'b1;

        //       name     clause    len pos neg emp uni inv idx  w3: len pos neg
        run_vec("empty",  16'h0000, 0,  0,  0,  1,  0,  0,  0,       0,  0,  0);
        run_vec("mixed",  16'h0009, 2,  1,  1,  0,  0,  0,  0,       2,  1,  1);
        run_vec("fullp",  16'h5555, 8,  8,  0,  0,  0,  0,  0,       7,  7,  0);
        run_vec("unit7",  16'h8000, 1,  0,  1,  0,  1,  0,  7,       1,  0,  1);
        run_vec("inv4",   16'h0300, 0,  0,  0,  1,  0,  1,  0,       0,  0,  0);
        run_vec("fulln",  16'hAAAA, 8,  0,  8,  0,  0,  0,  0,       7,  0,  7);
        run_vec("unit3i", 16'h0C40, 1,  1,  0,  0,  1,  1,  3,       1,  1,  0);
        run_vec("half",   16'h5A00, 4,  2,  2,  0,  0,  0,  4,       4,  2,  2);

        // valid_i low: registered build holds the last result, combinational build follows the input.
        drive(1'b0, 16'h0001);
        check("idle.valid", valid_o, 0);
`ifdef CLAUSE_LEN8_REG_OUT_EN
        check("idle.len_hold", len_o, 4);
        check("idle.idx_hold", idx_o, 4);
`else
        check("idle.len_comb", len_o, 1);
        check("idle.idx_comb", idx_o, 0);
`endif

        // Back-to-back clauses on consecutive cycles.
        run_vec("b2b0", 16'h0002, 1, 0, 1, 0, 1, 0, 0, 1, 0, 1);
        run_vec("b2b1", 16'h0014, 2, 2, 0, 0, 0, 0, 1, 2, 2, 0);
        run_vec("b2b2", 16'h2000, 1, 0, 1, 0, 1, 0, 6, 1, 0, 1);

        // Mid-cycle reset assertion.
        #2;
        rst = 1'b0;
        #1;
`ifdef CLAUSE_LEN8_REG_OUT_EN
        check("midrst.valid", valid_o, 0);
        check("midrst.len", len_o, 0);
        check("midrst.unit", unit_o, 0);
        check("midrst.idx", idx_o, 0);
        check("midrst.neg", neg_o, 0);
`else
        check("midrst.valid", valid_o, 1);
        check("midrst.len", len_o, 1);
        check("midrst.unit", unit_o, 1);
        check("midrst.idx", idx_o, 6);
        check("midrst.neg", neg_o, 1);
`endif
        @(negedge clk);
        rst = 1'b1;
        run_vec("postrst", 16'h0400, 1, 1, 0, 0, 1, 0, 5, 1, 1, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
